// File: rtl/adc_capture_sequencer.sv
// Multi-frame ADC capture sequencer: start/ack handshake per frame, inter-frame gap,
// trigger arming, overrun counting and adapter abort. Optional: ADC_CAPTURE_SEQUENCER_TIMESTAMP_EN.
module adc_capture_sequencer #(
   parameter int ACK_TIMEOUT  = 16,
   parameter int ABORT_CYCLES = 2,
   parameter int FRAME_W      = 16
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic               ctrl_start,
   input  logic               ctrl_abort,
   input  logic [31:0]        cfg_sample_count,
   input  logic [FRAME_W-1:0] cfg_frame_count,
   input  logic [15:0]        cfg_gap_cycles,
   input  logic               cfg_trig_mode,
   input  logic               ext_trigger,
   output logic [31:0]        adc_sample_count,
   output logic               adc_start_trigger,
   input  logic               adc_start_trigger_ack,
   input  logic [1:0]         adc_sample_state,
   output logic               adc_aresetn,
   input  logic               mon_tvalid,
   input  logic               mon_tready,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [FRAME_W-1:0] frames_done,
   output logic [15:0]        overrun_count,
`ifdef ADC_CAPTURE_SEQUENCER_TIMESTAMP_EN
   output logic [2:0]         seq_state,
   output logic [63:0]        frame_timestamp
`else
   output logic [2:0]         seq_state
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      REQ   = 3'd2,
      RUN   = 3'd3,
      GAP   = 3'd4,
      ABORT = 3'd5
   } seq_state_t;

   localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
   localparam int ABT_W = $clog2(ABORT_CYCLES + 1);

   seq_state_t         state;
   logic [FRAME_W-1:0] sh_frame_count;
   logic [15:0]        sh_gap_cycles;
   logic               prev_trigger;
   logic [ACK_W-1:0]   ack_cnt;
   logic [15:0]        gap_cnt;
   logic [ABT_W-1:0]   abort_cnt;
   logic [FRAME_W-1:0] frames_next;
   logic               last_frame;

   assign frames_next = frames_done + FRAME_W'(1);
   assign last_frame  = (sh_frame_count != '0) && (frames_next == sh_frame_count);
   assign seq_state   = state;
   // The adapter sits in reset both under our own reset and while an abort is in progress.
   assign adc_aresetn = ~areset & (state != ABORT);

   always_ff @(posedge aclk) begin
      if (areset) begin
         state             <= IDLE;
         busy              <= 1'b0;
         done              <= 1'b0;
         error             <= 1'b0;
         adc_start_trigger <= 1'b0;
         adc_sample_count  <= '0;
         frames_done       <= '0;
         overrun_count     <= '0;
         sh_frame_count    <= '0;
         sh_gap_cycles     <= '0;
         prev_trigger      <= 1'b0;
         ack_cnt           <= '0;
         gap_cnt           <= '0;
         abort_cnt         <= '0;
      end else begin
         done         <= 1'b0;
         prev_trigger <= ext_trigger;

         if (state == RUN && mon_tvalid && !mon_tready && overrun_count != 16'hFFFF)
            overrun_count <= overrun_count + 16'd1;

         if (ctrl_abort && state != IDLE) begin
            state             <= ABORT;
            busy              <= 1'b1;
            adc_start_trigger <= 1'b0;
            abort_cnt         <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (ctrl_start) begin
                     sh_frame_count   <= cfg_frame_count;
                     sh_gap_cycles    <= cfg_gap_cycles;
                     adc_sample_count <= cfg_sample_count;
                     frames_done      <= '0;
                     overrun_count    <= '0;
                     error            <= 1'b0;
                     ack_cnt          <= '0;
                     busy             <= 1'b1;
                     state            <= cfg_trig_mode ? ARM : REQ;
                  end
               end

               ARM: begin
                  if (ext_trigger && !prev_trigger) begin
                     ack_cnt <= '0;
                     state   <= REQ;
                  end
               end

               REQ: begin
                  if (adc_start_trigger_ack) begin
                     adc_start_trigger <= 1'b0;
                     state             <= RUN;
                  end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                     adc_start_trigger <= 1'b0;
                     error             <= 1'b1;
                     abort_cnt         <= '0;
                     state             <= ABORT;
                  end else begin
                     adc_start_trigger <= 1'b1;
                     ack_cnt           <= ack_cnt + ACK_W'(1);
                  end
               end

               // Sample state 0 inside RUN means the adapter has finished this frame.
               RUN: begin
                  if (adc_sample_state == 2'd0) begin
                     frames_done <= frames_next;
                     if (last_frame) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                     end else if (sh_gap_cycles == 16'd0) begin
                        ack_cnt <= '0;
                        state   <= REQ;
                     end else begin
                        gap_cnt <= '0;
                        state   <= GAP;
                     end
                  end
               end

               GAP: begin
                  if (gap_cnt == sh_gap_cycles - 16'd1) begin
                     ack_cnt <= '0;
                     state   <= REQ;
                  end else begin
                     gap_cnt <= gap_cnt + 16'd1;
                  end
               end

               ABORT: begin
                  if (abort_cnt == ABT_W'(ABORT_CYCLES - 1)) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     abort_cnt <= abort_cnt + ABT_W'(1);
                  end
               end

               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

`ifdef ADC_CAPTURE_SEQUENCER_TIMESTAMP_EN
   logic [63:0] cycle_count;

   // Timestamp marks the cycle a frame request is actually accepted by the adapter.
   always_ff @(posedge aclk) begin
      if (areset) begin
         cycle_count     <= '0;
         frame_timestamp <= '0;
      end else begin
         cycle_count <= cycle_count + 64'd1;
         if (state == REQ && adc_start_trigger_ack && !ctrl_abort)
            frame_timestamp <= cycle_count;
      end
   end
`endif

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer with a small ADC adapter model that
// acks one cycle after each request and then reports a busy frame for a set length.
module tb_adc_capture_sequencer;

   localparam int FW = 16;

   localparam int W_DONE  = 0;
   localparam int W_ERROR = 1;
   localparam int W_IDLE  = 2;
   localparam int W_RUN   = 3;
   localparam int W_RUN2  = 4;

   logic          aclk;
   logic          areset;
   logic          ctrl_start;
   logic          ctrl_abort;
   logic [31:0]   cfg_sample_count;
   logic [FW-1:0] cfg_frame_count;
   logic [15:0]   cfg_gap_cycles;
   logic          cfg_trig_mode;
   logic          ext_trigger;
   logic [31:0]   adc_sample_count;
   logic          adc_start_trigger;
   logic          adc_start_trigger_ack;
   logic [1:0]    adc_sample_state;
   logic          adc_aresetn;
   logic          mon_tvalid;
   logic          mon_tready;
   logic          busy;
   logic          done;
   logic          error;
   logic [FW-1:0] frames_done;
   logic [15:0]   overrun_count;
   logic [2:0]    seq_state;
`ifdef ADC_CAPTURE_SEQUENCER_TIMESTAMP_EN
   logic [63:0]   frame_timestamp;
`endif

   int checks = 0;
   int failures = 0;

   // Adapter model controls and monitor counters (written only by the model process)
   logic ack_enable;
   int   frame_len;
   logic req_seen;
   int   remaining;
   int   cycle_no = 0;
   int   hs_count = 0;
   int   done_count = 0;
   int   low_count = 0;
   int   req_count = 0;
   int   frame_end_cycle = 0;
   int   gap_dist = 0;
   logic prev_trig_mon = 1'b0;

   int hs_base, done_base, low_base, req_base;

   adc_capture_sequencer #(
      .ACK_TIMEOUT(16),
      .ABORT_CYCLES(2),
      .FRAME_W(FW)
   ) dut (
      .aclk(aclk),
      .areset(areset),
      .ctrl_start(ctrl_start),
      .ctrl_abort(ctrl_abort),
      .cfg_sample_count(cfg_sample_count),
      .cfg_frame_count(cfg_frame_count),
      .cfg_gap_cycles(cfg_gap_cycles),
      .cfg_trig_mode(cfg_trig_mode),
      .ext_trigger(ext_trigger),
      .adc_sample_count(adc_sample_count),
      .adc_start_trigger(adc_start_trigger),
      .adc_start_trigger_ack(adc_start_trigger_ack),
      .adc_sample_state(adc_sample_state),
      .adc_aresetn(adc_aresetn),
      .mon_tvalid(mon_tvalid),
      .mon_tready(mon_tready),
      .busy(busy),
      .done(done),
      .error(error),
      .frames_done(frames_done),
      .overrun_count(overrun_count),
      .seq_state(seq_state)
`ifdef ADC_CAPTURE_SEQUENCER_TIMESTAMP_EN
      ,.frame_timestamp(frame_timestamp)
`endif
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Adapter model updates first each negedge, then the monitor samples the settled cycle.
   initial begin : adapter_model
      adc_start_trigger_ack = 1'b0;
      adc_sample_state      = 2'd0;
      req_seen              = 1'b0;
      remaining             = 0;
      forever begin
         @(negedge aclk);
         if (areset || !adc_aresetn) begin
            adc_start_trigger_ack = 1'b0;
            adc_sample_state      = 2'd0;
            req_seen              = 1'b0;
            remaining             = 0;
         end else if (adc_start_trigger_ack) begin
            adc_start_trigger_ack = 1'b0;
            req_seen              = 1'b0;
         end else if (adc_sample_state == 2'd1) begin
            if (remaining == 0) adc_sample_state = 2'd0;
            else remaining = remaining - 1;
         end else if (adc_start_trigger && ack_enable) begin
            if (req_seen) begin
               adc_start_trigger_ack = 1'b1;
               adc_sample_state      = 2'd1;
               remaining             = frame_len - 1;
            end else begin
               req_seen = 1'b1;
            end
         end

         cycle_no = cycle_no + 1;
         if (adc_start_trigger && adc_start_trigger_ack) hs_count = hs_count + 1;
         if (done) done_count = done_count + 1;
         if (!areset && !adc_aresetn) low_count = low_count + 1;
         if (seq_state == 3'd2) req_count = req_count + 1;
         if (seq_state == 3'd3 && adc_sample_state == 2'd0) frame_end_cycle = cycle_no;
         if (adc_start_trigger && !prev_trig_mon) gap_dist = cycle_no - frame_end_cycle;
         prev_trig_mon = adc_start_trigger;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; leaves the bench in the first cycle after the start edge.
   task automatic applyStimulus(input logic [31:0] samples, input logic [FW-1:0] frames,
                                input logic [15:0] gap, input logic mode);
      hs_base          = hs_count;
      done_base        = done_count;
      low_base         = low_count;
      req_base         = req_count;
      cfg_sample_count = samples;
      cfg_frame_count  = frames;
      cfg_gap_cycles   = gap;
      cfg_trig_mode    = mode;
      ctrl_start       = 1'b1;
      @(negedge aclk);
      ctrl_start       = 1'b0;
   endtask

   task automatic waitFor(input int what, input string tag, input int budget);
      logic reached;
      reached = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge aclk);
         case (what)
            W_DONE:  reached = done;
            W_ERROR: reached = error;
            W_IDLE:  reached = (seq_state == 3'd0);
            W_RUN:   reached = (seq_state == 3'd3);
            W_RUN2:  reached = (seq_state == 3'd3) && (frames_done == 16'd1);
            default: reached = 1'b1;
         endcase
         if (reached) break;
      end
      checkOutput({tag, "_reached"}, 64'(reached), 64'd1);
   endtask

   initial begin : stimulus
      areset           = 1'b1;
      ctrl_start       = 1'b0;
      ctrl_abort       = 1'b0;
      cfg_sample_count = '0;
      cfg_frame_count  = '0;
      cfg_gap_cycles   = '0;
      cfg_trig_mode    = 1'b0;
      ext_trigger      = 1'b0;
      mon_tvalid       = 1'b0;
      mon_tready       = 1'b1;
      ack_enable       = 1'b1;
      frame_len        = 4;

      // Reset state
      repeat (3) @(negedge aclk);
      checkOutput("rst_state", seq_state, 3'd0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_error", error, 1'b0);
      checkOutput("rst_trigger", adc_start_trigger, 1'b0);
      checkOutput("rst_frames", frames_done, 16'd0);
      checkOutput("rst_overrun", overrun_count, 16'd0);
      checkOutput("rst_samples", adc_sample_count, 32'd0);
      checkOutput("rst_aresetn", adc_aresetn, 1'b0);
      areset = 1'b0;
      @(negedge aclk);
      checkOutput("rel_aresetn", adc_aresetn, 1'b1);

      // Abort in IDLE is a no-op
      ctrl_abort = 1'b1;
      @(negedge aclk);
      ctrl_abort = 1'b0;
      checkOutput("idle_abort_state", seq_state, 3'd0);
      checkOutput("idle_abort_aresetn", adc_aresetn, 1'b1);

      // Single frame
      $display("[TB] single frame");
      applyStimulus(32'd4, 16'd1, 16'd0, 1'b0);
      checkOutput("sf_entry_state", seq_state, 3'd2);
      checkOutput("sf_entry_trigger", adc_start_trigger, 1'b0);
      checkOutput("sf_busy", busy, 1'b1);
      checkOutput("sf_samples", adc_sample_count, 32'd4);
      @(negedge aclk);
      checkOutput("sf_trigger_high", adc_start_trigger, 1'b1);
      waitFor(W_DONE, "sf_done", 100);
      checkOutput("sf_frames", frames_done, 16'd1);
      checkOutput("sf_hs", 64'(hs_count - hs_base), 64'd1);
      @(negedge aclk);
      checkOutput("sf_busy_after", busy, 1'b0);
      checkOutput("sf_done_pulse", done, 1'b0);
      checkOutput("sf_done_count", 64'(done_count - done_base), 64'd1);

      // Multi-frame with gap
      $display("[TB] multi frame gap");
      applyStimulus(32'd4, 16'd3, 16'd5, 1'b0);
      waitFor(W_DONE, "mf_done", 300);
      checkOutput("mf_frames", frames_done, 16'd3);
      checkOutput("mf_hs", 64'(hs_count - hs_base), 64'd3);
      checkOutput("mf_gap_dist", 64'(gap_dist), 64'd7);
      repeat (10) @(negedge aclk);
      checkOutput("mf_done_count", 64'(done_count - done_base), 64'd1);
      checkOutput("mf_error", error, 1'b0);

      // External trigger
      $display("[TB] external trigger");
      ext_trigger = 1'b1;
      @(negedge aclk);
      applyStimulus(32'd4, 16'd1, 16'd0, 1'b1);
      checkOutput("et_arm", seq_state, 3'd1);
      repeat (3) @(negedge aclk);
      checkOutput("et_arm_hold", seq_state, 3'd1);
      checkOutput("et_no_trigger", adc_start_trigger, 1'b0);
      ext_trigger = 1'b0;
      @(negedge aclk);
      ext_trigger = 1'b1;
      checkOutput("et_arm_low", seq_state, 3'd1);
      @(negedge aclk);
      checkOutput("et_req", seq_state, 3'd2);
      waitFor(W_DONE, "et_done", 100);
      checkOutput("et_frames", frames_done, 16'd1);
      ext_trigger = 1'b0;
      @(negedge aclk);

      // Ack timeout
      $display("[TB] ack timeout");
      ack_enable = 1'b0;
      applyStimulus(32'd4, 16'd1, 16'd0, 1'b0);
      waitFor(W_ERROR, "to_error", 40);
      checkOutput("to_req_cycles", 64'(req_count - req_base), 64'd16);
      checkOutput("to_abort_state", seq_state, 3'd5);
      checkOutput("to_aresetn", adc_aresetn, 1'b0);
      waitFor(W_IDLE, "to_idle", 10);
      checkOutput("to_low_cycles", 64'(low_count - low_base), 64'd2);
      checkOutput("to_no_done", 64'(done_count - done_base), 64'd0);
      checkOutput("to_error_sticky", error, 1'b1);
      checkOutput("to_busy", busy, 1'b0);
      ack_enable = 1'b1;
      applyStimulus(32'd4, 16'd1, 16'd0, 1'b0);
      checkOutput("to_error_clear", error, 1'b0);
      waitFor(W_DONE, "to_recover_done", 100);
      @(negedge aclk);

      // Abort mid-RUN in continuous mode, with a simultaneous ignored start
      $display("[TB] abort continuous");
      applyStimulus(32'd6, 16'd0, 16'd3, 1'b0);
      waitFor(W_RUN2, "ab_run2", 200);
      ctrl_abort       = 1'b1;
      ctrl_start       = 1'b1;
      cfg_sample_count = 32'd9;
      cfg_frame_count  = 16'd5;
      @(negedge aclk);
      ctrl_abort = 1'b0;
      ctrl_start = 1'b0;
      checkOutput("ab_state", seq_state, 3'd5);
      checkOutput("ab_aresetn", adc_aresetn, 1'b0);
      checkOutput("ab_busy", busy, 1'b1);
      waitFor(W_IDLE, "ab_idle", 10);
      checkOutput("ab_low_cycles", 64'(low_count - low_base), 64'd2);
      checkOutput("ab_frames_hold", frames_done, 16'd1);
      checkOutput("ab_no_done", 64'(done_count - done_base), 64'd0);
      repeat (3) @(negedge aclk);
      checkOutput("ab_start_ignored", seq_state, 3'd0);
      checkOutput("ab_samples_kept", adc_sample_count, 32'd6);

      // Overrun counting
      $display("[TB] overrun");
      frame_len = 20;
      applyStimulus(32'd20, 16'd1, 16'd0, 1'b0);
      waitFor(W_RUN, "ov_run", 20);
      mon_tvalid = 1'b1;
      mon_tready = 1'b0;
      repeat (10) @(negedge aclk);
      mon_tready = 1'b1;
      repeat (5) @(negedge aclk);
      mon_tvalid = 1'b0;
      waitFor(W_DONE, "ov_done", 100);
      checkOutput("ov_count", overrun_count, 16'd10);
      mon_tvalid = 1'b1;
      mon_tready = 1'b0;
      repeat (5) @(negedge aclk);
      mon_tvalid = 1'b0;
      mon_tready = 1'b1;
      checkOutput("ov_idle_nocount", overrun_count, 16'd10);

      // Overrun saturation
      $display("[TB] overrun saturation");
      frame_len = 70100;
      applyStimulus(32'd70100, 16'd1, 16'd0, 1'b0);
      waitFor(W_RUN, "sat_run", 20);
      mon_tvalid = 1'b1;
      mon_tready = 1'b0;
      repeat (65534) @(negedge aclk);
      checkOutput("sat_fffe", overrun_count, 16'hFFFE);
      @(negedge aclk);
      checkOutput("sat_ffff", overrun_count, 16'hFFFF);
      repeat (4465) @(negedge aclk);
      checkOutput("sat_hold", overrun_count, 16'hFFFF);
      mon_tvalid = 1'b0;
      mon_tready = 1'b1;
      ctrl_abort = 1'b1;
      @(negedge aclk);
      ctrl_abort = 1'b0;
      waitFor(W_IDLE, "sat_idle", 10);
      checkOutput("sat_after_abort", overrun_count, 16'hFFFF);

      // Reset mid-sequence
      $display("[TB] reset mid-sequence");
      frame_len = 4;
      applyStimulus(32'd4, 16'd2, 16'd2, 1'b0);
      waitFor(W_RUN, "mr_run", 20);
      areset = 1'b1;
      @(negedge aclk);
      checkOutput("mr_state", seq_state, 3'd0);
      checkOutput("mr_busy", busy, 1'b0);
      checkOutput("mr_samples", adc_sample_count, 32'd0);
      checkOutput("mr_aresetn", adc_aresetn, 1'b0);
      areset = 1'b0;
      @(negedge aclk);
      checkOutput("mr_aresetn_rel", adc_aresetn, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_capture_sequencer.md
Name: adc_capture_sequencer

Overview:
Sequences multi-frame ADC captures through the ADC data adapter. It latches a capture configuration and optionally waits for an external trigger. For each frame it issues a start/ack handshake to the adapter, detects frame completion from the adapter's sample state, and inserts a programmable gap between frames. It also counts downstream back-pressure overruns and can abort the adapter mid-frame through its reset.

Parameters:
ACK_TIMEOUT, 16, max cycles in REQ waiting for adc_start_trigger_ack before error
ABORT_CYCLES, 2, cycles adc_aresetn is held low on abort
FRAME_W, 16, width of frame count/status counters

Ports:
aclk  in  1  global clock
areset  in  1  synchronous, active-high reset
ctrl_start  in  1  single-cycle pulse; latches cfg_* and starts sequence
ctrl_abort  in  1  single-cycle pulse; aborts any active sequence
cfg_sample_count  in  32  per-frame sample count passed to adapter
cfg_frame_count  in  FRAME_W  frames per sequence; 0 = continuous until abort
cfg_gap_cycles  in  16  idle cycles between frames
cfg_trig_mode  in  1  0 = immediate, 1 = wait ext_trigger rising edge before first frame
ext_trigger  in  1  external trigger, already synchronised to aclk
adc_sample_count  out  32  to adapter sample_count
adc_start_trigger  out  1  to adapter start_trigger
adc_start_trigger_ack  in  1  from adapter
adc_sample_state  in  2  from adapter sample_state
adc_aresetn  out  1  active-low reset to adapter
mon_tvalid  in  1  adapter m_axis_tvalid (monitor)
mon_tready  in  1  downstream m_axis_tready (monitor)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal sequence completion
error  out  1  sticky ack-timeout flag; cleared by next accepted ctrl_start
frames_done  out  FRAME_W  frames completed in current or last sequence
overrun_count  out  16  cycles with mon_tvalid & ~mon_tready in RUN; saturates at 0xFFFF
seq_state  out  3  current FSM state encoding

Behaviour:
- Reset values, synchronous on areset: state IDLE; busy, done, error, adc_start_trigger = 0; frames_done, overrun_count, adc_sample_count = 0.
- adc_aresetn = ~areset & ~abort_active, so the adapter is also held in reset while areset is high.
- All outputs are registered except adc_aresetn.
- States and encodings: IDLE=0, ARM=1, REQ=2, RUN=3, GAP=4, ABORT=5.
- IDLE: ctrl_start → latch cfg_* into shadow registers; clear frames_done, overrun_count and error; adc_sample_count <= cfg_sample_count.
  - Next state is ARM if cfg_trig_mode=1, else REQ.
- ARM: edge detect uses the registered previous ext_trigger. ext_trigger high with previous value low → REQ.
  - ext_trigger already high on entry does not count as an edge.
- REQ: adc_start_trigger=1 from the cycle after entry.
  - On adc_start_trigger_ack=1 → adc_start_trigger <= 0 and go to RUN.
  - Ack timeout counter starts at 0 on entry. If it reaches ACK_TIMEOUT with no ack → error <= 1, then ABORT.
- RUN: the adapter reports state 1 in the ack cycle. Frame is complete on the first RUN cycle with adc_sample_state==0; frames_done increments that cycle.
  - If frames_done+1 == shadow frame count (count non-zero) → IDLE with done pulse.
  - Otherwise → GAP, or straight to REQ if gap=0.
  - Overrun counting is active only in RUN.
- GAP: wait exactly shadow cfg_gap_cycles cycles, then REQ.
- ABORT: adc_aresetn low for ABORT_CYCLES cycles, then IDLE. No done pulse; frames_done holds.
- Priority: ctrl_abort in any non-IDLE state wins over every other transition → ABORT. ctrl_abort in IDLE does nothing. ctrl_start while busy is ignored.
- Continuous mode: frames_done wraps modulo 2^FRAME_W and never produces done.
- A cfg_* change while busy has no effect until the next ctrl_start.
- areset mid-sequence: immediate return to IDLE with reset values; the adapter is held in reset through adc_aresetn.

Optional Feature:
ADC_CAPTURE_SEQUENCER_TIMESTAMP_EN
- Defined: adds a 64-bit free-running cycle counter (reset 0) and output port frame_timestamp [63:0]. frame_timestamp latches the counter value in each cycle where REQ sees the ack; reset value 0.
- Undefined: no counter and no frame_timestamp port; all other behaviour is identical.

Test Plan:
- Single frame: sample_count=4, frame_count=1, gap=0, mode=0, adapter model acks 1 cycle after the request → exactly one start_trigger handshake, frames_done=1, one done pulse, busy low the cycle after done.
- Multi-frame with gap: frame_count=3, gap=5 → 3 handshakes; between frame end and the next start_trigger there are 5 GAP cycles + 1; frames_done=3; done pulses once.
- External trigger: mode=1, ext_trigger held high before ctrl_start → stays in ARM. After a low→high transition, REQ follows on the next cycle.
- Ack timeout: adapter model never acks → error=1 after 16 REQ cycles, adc_aresetn low for 2 cycles, IDLE, no done. The next ctrl_start clears error.
- Abort mid-RUN with continuous mode: frame_count=0, ctrl_abort during the 2nd frame → ABORT, adc_aresetn low 2 cycles, frames_done=1 holds. A simultaneous ctrl_start is ignored.
- Overrun: mon_tready held low for 10 cycles of tvalid in RUN → overrun_count=10. Forcing 70000 such cycles → saturates at 0xFFFF.
